// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with programmable wait states and byte-enabled stores.
// Define DMEM_RESPONDER_ERR_EN to add misalignment/range fault checking on requests.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wval,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rval,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wval_q, wval_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rval_q, rval_d;
    logic              err_q, err_d;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              commit;
    logic              fault;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wval;
    logic [3:0]        cur_be;
    logic [IDX_W-1:0]  idx;

    // With zero wait states the commit edge is the accept edge, so the live request is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we   = req_we;
            cur_addr = req_addr;
            cur_wval = req_wval;
            cur_be   = req_be;
        end else begin
            cur_we   = we_q;
            cur_addr = addr_q;
            cur_wval = wval_q;
            cur_be   = be_q;
        end
        idx = cur_addr[IDX_W+1:2];
    end

`ifdef DMEM_RESPONDER_ERR_EN
    logic misalign;
    logic out_of_range;

    always_comb begin
        misalign = ((cur_be == 4'b1111) && (cur_addr[1:0] != 2'b00))
                || (((cur_be == 4'b0011) || (cur_be == 4'b1100)) && cur_addr[0]);
        out_of_range = (cur_addr >> (IDX_W + 2)) != '0;
        fault = misalign || out_of_range;
    end
`else
    logic unused_addr_bits;

    assign fault            = 1'b0;
    assign unused_addr_bits = ^{cur_addr >> (IDX_W + 2), cur_addr[1:0]};
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wval_d  = wval_q;
        be_d    = be_q;
        rval_d  = rval_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    addr_d = req_addr;
                    wval_d = req_wval;
                    be_d   = req_be;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            err_d  = fault;
            rval_d = (cur_we || fault) ? 32'd0 : mem[idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rval_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rval_q  <= rval_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        we_q   <= we_d;
        addr_q <= addr_d;
        wval_q <= wval_d;
        be_q   <= be_d;
    end

    // NOTE: the storage array has no reset; a commit on a reset edge still lands.
    always_ff @(posedge clock) begin
        if (commit && cur_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wval[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rval  = rval_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with 1, 0 and 3 wait states.
// Expectations follow DMEM_RESPONDER_ERR_EN when the bench is built with it defined.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rval;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  vld;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wval;
    logic [3:0]  req_be;

    logic        rdy0, rdy1, rdy2;
    logic        rv0, rv1, rv2;
    logic        err0, err1, err2;
    logic [31:0] rval0, rval1, rval2;
    logic [2:0]  rdy, rv, err;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign rdy = {rdy2, rdy1, rdy0};
    assign rv  = {rv2, rv1, rv0};
    assign err = {err2, err1, err0};

    dmem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_wval(req_wval), .req_be(req_be),
        .rsp_valid(rv0), .rsp_rval(rval0), .rsp_err(err0)
    );

    dmem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_wval(req_wval), .req_be(req_be),
        .rsp_valid(rv1), .rsp_rval(rval1), .rsp_err(err1)
    );

    dmem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy2),
        .req_we(req_we), .req_addr(req_addr), .req_wval(req_wval), .req_be(req_be),
        .rsp_valid(rv2), .rsp_rval(rval2), .rsp_err(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] rval_of(input int sel);
        case (sel)
            0:       return rval0;
            1:       return rval1;
            default: return rval2;
        endcase
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int sel, input logic [31:0] r, input logic e);
        exp_t x;
        x.rval = r;
        x.err  = e;
        case (sel)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic score(input int sel);
        exp_t x;
        check($sformatf("u%0d_rsp_expected", sel), 32'(qsize(sel) != 0), 32'd1);
        if (qsize(sel) != 0) begin
            case (sel)
                0:       x = q0.pop_front();
                1:       x = q1.pop_front();
                default: x = q2.pop_front();
            endcase
            check($sformatf("u%0d_rsp_rval", sel), rval_of(sel), x.rval);
            check($sformatf("u%0d_rsp_err", sel), 32'(err[sel]), 32'(x.err));
        end
    endtask

    always @(negedge clock) begin
        if (rv[0] === 1'b1) score(0);
        if (rv[1] === 1'b1) score(1);
        if (rv[2] === 1'b1) score(2);
    end

    task automatic drive_accept(input int sel, input logic we, input logic [31:0] addr,
                                input logic [31:0] wval, input logic [3:0] be, output bit ok);
        ok = 1'b0;
        @(posedge clock);
        #1;
        req_we   = we;
        req_addr = addr;
        req_wval = wval;
        req_be   = be;
        vld[sel] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (rdy[sel] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end
        vld[sel] = 1'b0;
        check($sformatf("u%0d_accept", sel), 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input int sel);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (qsize(sel) == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check($sformatf("u%0d_drain", sel), 32'(done), 32'd1);
    endtask

    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wval, input logic [3:0] be,
                          input logic [31:0] exp_rval, input logic exp_err, input bit lat);
        bit ok;
        int ws;
        ws = ws_of(sel);
        drive_accept(sel, we, addr, wval, be, ok);
        if (!ok) return;
        push_exp(sel, exp_rval, exp_err);
        if (lat) begin
            for (int k = 1; k <= ws + 2; k++) begin
                @(negedge clock);
                check($sformatf("u%0d_lat_rsp_valid_c%0d", sel, k), 32'(rv[sel]), 32'(k == ws + 1));
                check($sformatf("u%0d_lat_req_ready_c%0d", sel, k), 32'(rdy[sel]), 32'(k == ws + 2));
            end
        end
        wait_drain(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        bit seen;
        int j;

        rst      = 3'b111;
        vld      = 3'b000;
        req_we   = 1'b0;
        req_addr = 32'd0;
        req_wval = 32'd0;
        req_be   = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        rst = 3'b000;
        @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("u%0d_reset_req_ready", s), 32'(rdy[s]), 32'd1);
            check($sformatf("u%0d_reset_rsp_valid", s), 32'(rv[s]), 32'd0);
            check($sformatf("u%0d_reset_rsp_rval", s), rval_of(s), 32'd0);
            check($sformatf("u%0d_reset_rsp_err", s), 32'(err[s]), 32'd0);
        end

        // One wait state: latency, byte lanes, no-op store, wrap or faults.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0, 1'b1);
        do_req(0, 1'b0, 32'h10, 32'd0, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'd0, 1'b0, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 1'b0);
        do_req(0, 1'b0, 32'h20, 32'd0, 4'b1111, 32'h11BB33DD, 1'b0, 1'b0);
        do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
        do_req(0, 1'b1, 32'h4, 32'h77, 4'b1111, 32'd0, 1'b0, 1'b0);
        do_req(0, 1'b1, 32'h1004, 32'h5, 4'b1111, 32'd0, ERR_EN, 1'b0);
        do_req(0, 1'b0, 32'h4, 32'd0, 4'b1111, ERR_EN ? 32'h77 : 32'h5, 1'b0, 1'b0);
        do_req(0, 1'b0, 32'h6, 32'd0, 4'b1111, ERR_EN ? 32'h0 : 32'h5, ERR_EN, 1'b0);
        do_req(0, 1'b1, 32'h8, 32'h88, 4'b1111, 32'd0, 1'b0, 1'b0);
        do_req(0, 1'b0, 32'h8, 32'd0, 4'b1111, 32'h88, 1'b0, 1'b0);
        @(negedge clock);
        check("u0_rval_hold", rval_of(0), 32'h88);
        check("u0_valid_low_after_rsp", 32'(rv[0]), 32'd0);
        do_req(0, 1'b0, 32'h1010, 32'd0, 4'b1111, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN, 1'b0);
        do_req(0, 1'b0, 32'h11, 32'd0, 4'b0011, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN, 1'b0);

        // Zero wait states: seed four words, then back-to-back loads with req_valid held.
        do_req(1, 1'b1, 32'h0, 32'hA0, 4'b1111, 32'd0, 1'b0, 1'b1);
        for (int w = 1; w < 4; w++) begin
            do_req(1, 1'b1, 32'(w * 4), 32'hA0 + 32'(w), 4'b1111, 32'd0, 1'b0, 1'b0);
        end
        @(posedge clock);
        #1;
        j        = 0;
        req_we   = 1'b0;
        req_be   = 4'b1111;
        req_addr = 32'h0;
        vld[1]   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("u1_b2b_req_ready_c%0d", k), 32'(rdy[1]), 32'(k % 2 == 0));
            check($sformatf("u1_b2b_rsp_valid_c%0d", k), 32'(rv[1]), 32'(k % 2 == 1));
            if (rdy[1] === 1'b1) begin
                push_exp(1, 32'hA0 + 32'(j), 1'b0);
                @(posedge clock);
                #1;
                j++;
                req_addr = 32'(j * 4);
            end
        end
        vld[1] = 1'b0;
        wait_drain(1);
        check("u1_b2b_accept_count", 32'(j), 32'd4);

        // Three wait states: reset during the second WAIT cycle drops the store.
        do_req(2, 1'b1, 32'h30, 32'h12345678, 4'b1111, 32'd0, 1'b0, 1'b1);
        drive_accept(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, ok);
        @(posedge clock);
        #1;
        rst[2] = 1'b1;
        @(posedge clock);
        #1;
        rst[2] = 1'b0;
        @(negedge clock);
        check("u2_ready_after_reset", 32'(rdy[2]), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rv[2] === 1'b1) seen = 1'b1;
            @(negedge clock);
        end
        check("u2_no_rsp_after_reset", 32'(seen), 32'd0);
        do_req(2, 1'b0, 32'h30, 32'd0, 4'b1111, 32'h12345678, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU's data-memory port.
- Accepts one load/store request at a time through a valid/ready handshake and applies a programmable number of wait states.
- Commits byte-enabled writes to an internal word array and returns read data with a one-cycle response pulse.
- Sits between the CPU data port and the storage as a cycle-accurate, handshaked alternative to a zero-latency RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- WAIT_STATES, 1, extra cycles between accept and response; range 0..15.
- ADDR_W, 32, request address width in bits.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wval  in  32  store data, little-endian byte lanes.
- req_be  in  4  byte enables; be[i] selects bits 8i+7:8i.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rval  out  32  load data; valid only while rsp_valid = 1.
- rsp_err  out  1  request faulted; valid only while rsp_valid = 1.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rval=0, rsp_err=0, wait counter=0.
  - Memory array contents are not reset.
- Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_ready is 1 only in IDLE; requests presented in any other state are ignored.
  - The requester holds req_* stable until accepted.
- On accept: latch we, addr, wval, be into the request register.
- FSM:
  - IDLE: accept → WAIT if WAIT_STATES>0, loading cnt=WAIT_STATES-1; accept → RESP if WAIT_STATES=0.
  - WAIT: if cnt==0 → RESP, else cnt decrements.
  - RESP: rsp_valid=1 for exactly one cycle, then → IDLE.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+1, where N is the accept edge.
  - Minimum request spacing: WAIT_STATES+2 cycles.
- Commit: the memory read or write happens on the edge that enters RESP.
  - rsp_rval is registered on that same edge.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads: rsp_rval = full word at index; req_be is ignored.
- Stores: only bytes with be[i]=1 are updated. rsp_rval = 0.
  - be=0000 is a legal no-op that still produces a response.
- Store then load to the same word: the load sees the new data, since the store committed earlier.
- Reset mid-operation (WAIT or RESP): return to IDLE next edge and clear rsp_valid.
  - A store not yet committed is dropped.
  - A store committed on the same edge that reset is sampled still commits; reset has priority over the FSM only.
- rsp_rval and rsp_err hold their last values outside RESP. Consumers must qualify them with rsp_valid.

Optional Feature:
- Macro: DMEM_RESPONDER_ERR_EN.
- Defined: fault checking on the latched request.
  - Misalignment fault:
    - be=1111 with addr[1:0]≠0.
    - be=0011 or 1100 with addr[0]=1.
  - Range fault: addr ≥ DEPTH_WORDS*4.
  - On a fault: rsp_err=1, store suppressed (memory unchanged), rsp_rval=0. Timing is identical to a normal response.
- Undefined: rsp_err is constant 0, addr[1:0] is ignored, and out-of-range addresses wrap.

Test Plan:
- Reset, then WAIT_STATES=1. Store 0xDEADBEEF to 0x10 with be=1111, accepted at edge N → rsp_valid=1 only in cycle N+2, req_ready=0 in cycles N+1..N+2. Then load 0x10 → rsp_rval=0xDEADBEEF.
- Word 0x20 holds 0x11223344. Store 0xAABBCCDD with be=0101, then load → 0x11BB33DD.
- WAIT_STATES=0 variant: hold req_valid=1 continuously with back-to-back loads → accepts every 2nd cycle, rsp_valid on alternating cycles.
- Store 0x5 to addr DEPTH_WORDS*4+4, then load addr 0x4:
  - Macro off → reads 0x5.
  - Macro on → the store returns rsp_err=1, and address 0x4 is unchanged.
- Macro on: load with be=1111 at 0x6 → rsp_err=1, rsp_rval=0. Aligned load at 0x8 → rsp_err=0.
- WAIT_STATES=3: assert reset for one cycle in the second WAIT cycle of a store to 0x30 → rsp_valid never rises, req_ready=1 after reset, and a load of 0x30 returns the old value.
